mem_mshr_ctrl: RTL and testbench

//  Miss-status holding controller for the global-memory path of the MEM unit. Each cache miss

---
 rtl/mem_mshr_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_mshr_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_mshr_ctrl.sv
// mem_mshr_ctrl: miss-status holding controller for the MEM unit global-memory path.
//
// Each accepted stage-2 miss claims the lowest-index idle entry. The entry then counts
// down its miss latency and competes round-robin for the single fill/replay port into
// stage 3. Each accepted miss also raises a registered one-cycle negative-feedback pulse
// to the scoreboard. Combinational address probes report outstanding lines.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   alloc_*_i / alloc_ready_o   miss allocation handshake (valid & ready)
//   fill_*_o / fill_ready_i     fill port handshake (valid & ready)
//   neg_fb_*_o                  one-cycle replay request to the scoreboard
//   probe_addr_i / probe_hit_o  outstanding-line lookup (combinational)
//   occupancy_o                 registered count of non-idle entries
module mem_mshr_ctrl #(
   parameter int unsigned NUM_ENTRIES = 4,
   parameter int unsigned ADDR_W      = 27,
   parameter int unsigned LAT_W       = 5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             alloc_valid_i,
   input  logic [ADDR_W-1:0]                alloc_addr_i,
   input  logic [LAT_W-1:0]                 alloc_latency_i,
   input  logic [2:0]                       alloc_warp_id_i,
   input  logic [1:0]                       alloc_scb_id_i,
   output logic                             alloc_ready_o,
   output logic                             fill_valid_o,
   output logic [ADDR_W-1:0]                fill_addr_o,
   output logic [2:0]                       fill_warp_id_o,
   output logic [1:0]                       fill_scb_id_o,
   input  logic                             fill_ready_i,
   output logic                             neg_fb_valid_o,
   output logic [2:0]                       neg_fb_warp_id_o,
   output logic [1:0]                       neg_fb_scb_id_o,
   input  logic [ADDR_W-1:0]                probe_addr_i,
   output logic                             probe_hit_o,
   output logic [$clog2(NUM_ENTRIES):0]     occupancy_o
);

   localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
   localparam int unsigned OCC_W = IDX_W + 1;

   typedef enum logic [1:0] {StIdle, StWait, StReady} ent_st_e;

   ent_st_e           st_q     [NUM_ENTRIES];
   ent_st_e           st_d     [NUM_ENTRIES];
   logic [LAT_W-1:0]  cnt_q    [NUM_ENTRIES];
   logic [LAT_W-1:0]  cnt_d    [NUM_ENTRIES];
   logic [ADDR_W-1:0] addr_q   [NUM_ENTRIES];
   logic [ADDR_W-1:0] addr_d   [NUM_ENTRIES];
   logic [2:0]        warp_q   [NUM_ENTRIES];
   logic [2:0]        warp_d   [NUM_ENTRIES];
   logic [1:0]        scb_q    [NUM_ENTRIES];
   logic [1:0]        scb_d    [NUM_ENTRIES];

   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              hold_q, hold_d;
   logic [IDX_W-1:0]  hold_idx_q, hold_idx_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              neg_valid_q, neg_valid_d;
   logic [2:0]        neg_warp_q, neg_warp_d;
   logic [1:0]        neg_scb_q, neg_scb_d;

   logic              alloc_found;
   logic [IDX_W-1:0]  alloc_idx;
   logic              gnt_found;
   logic [IDX_W-1:0]  gnt_idx;
   logic [IDX_W-1:0]  cand;
   logic              alloc_fire;
   logic              fill_fire;
   logic              hit;

   // Lowest-index idle entry, from registered state only.
   always_comb begin
      alloc_found = 1'b0;
      alloc_idx   = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (st_q[i] == StIdle) begin
            alloc_found = 1'b1;
            alloc_idx   = IDX_W'(i);
         end
      end
   end

   // Round-robin grant. A presented-but-stalled entry stays granted so that a newly ready
   // entry between rr_ptr and the presented one cannot pre-empt it.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      if (hold_q) begin
         gnt_found = 1'b1;
         gnt_idx   = hold_idx_q;
      end else begin
         for (int k = 0; k < NUM_ENTRIES; k++) begin
            cand = rr_ptr_q + IDX_W'(k);
            if (!gnt_found && (st_q[cand] == StReady)) begin
               gnt_found = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
   end

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if ((st_q[i] != StIdle) && (addr_q[i] == probe_addr_i)) begin
            hit = 1'b1;
         end
      end
   end

   assign alloc_fire = alloc_valid_i & alloc_found;
   assign fill_fire  = gnt_found & fill_ready_i;

   assign alloc_ready_o    = alloc_found;
   assign fill_valid_o     = gnt_found;
   assign fill_addr_o      = addr_q[gnt_idx];
   assign fill_warp_id_o   = warp_q[gnt_idx];
   assign fill_scb_id_o    = scb_q[gnt_idx];
   assign neg_fb_valid_o   = neg_valid_q;
   assign neg_fb_warp_id_o = neg_warp_q;
   assign neg_fb_scb_id_o  = neg_scb_q;
   assign probe_hit_o      = hit;
   assign occupancy_o      = occ_q;

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         st_d[i]   = st_q[i];
         cnt_d[i]  = cnt_q[i];
         addr_d[i] = addr_q[i];
         warp_d[i] = warp_q[i];
         scb_d[i]  = scb_q[i];
         case (st_q[i])
            StWait: begin
               // Saturating countdown; the last count moves straight to READY.
               if (cnt_q[i] <= LAT_W'(1)) begin
                  st_d[i]  = StReady;
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] - LAT_W'(1);
               end
            end
            StReady: begin
               if (fill_fire && (gnt_idx == IDX_W'(i))) begin
                  st_d[i] = StIdle;
               end
            end
            default: ;
         endcase
      end

      // Alloc targets an idle entry and fill a ready one, so they never collide.
      // Latency 0 or 1 makes the entry ready in the very next cycle.
      if (alloc_fire) begin
         if (alloc_latency_i <= LAT_W'(1)) begin
            st_d[alloc_idx]  = StReady;
            cnt_d[alloc_idx] = '0;
         end else begin
            st_d[alloc_idx]  = StWait;
            cnt_d[alloc_idx] = alloc_latency_i - LAT_W'(1);
         end
         addr_d[alloc_idx] = alloc_addr_i;
         warp_d[alloc_idx] = alloc_warp_id_i;
         scb_d[alloc_idx]  = alloc_scb_id_i;
      end

      rr_ptr_d   = fill_fire ? (gnt_idx + IDX_W'(1)) : rr_ptr_q;
      hold_d     = gnt_found & ~fill_ready_i;
      hold_idx_d = gnt_idx;

      occ_d = occ_q;
      if (alloc_fire && !fill_fire) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!alloc_fire && fill_fire) begin
         occ_d = occ_q - OCC_W'(1);
      end

      neg_valid_d = alloc_fire;
      neg_warp_d  = alloc_fire ? alloc_warp_id_i : neg_warp_q;
      neg_scb_d   = alloc_fire ? alloc_scb_id_i : neg_scb_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            st_q[i]   <= StIdle;
            cnt_q[i]  <= '0;
            addr_q[i] <= '0;
            warp_q[i] <= '0;
            scb_q[i]  <= '0;
         end
         rr_ptr_q    <= '0;
         hold_q      <= 1'b0;
         hold_idx_q  <= '0;
         occ_q       <= '0;
         neg_valid_q <= 1'b0;
         neg_warp_q  <= '0;
         neg_scb_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            st_q[i]   <= st_d[i];
            cnt_q[i]  <= cnt_d[i];
            addr_q[i] <= addr_d[i];
            warp_q[i] <= warp_d[i];
            scb_q[i]  <= scb_d[i];
         end
         rr_ptr_q    <= rr_ptr_d;
         hold_q      <= hold_d;
         hold_idx_q  <= hold_idx_d;
         occ_q       <= occ_d;
         neg_valid_q <= neg_valid_d;
         neg_warp_q  <= neg_warp_d;
         neg_scb_q   <= neg_scb_d;
      end
   end

endmodule

// File: tb/tb_mem_mshr_ctrl.sv
// tb_mem_mshr_ctrl: bench for mem_mshr_ctrl. Keeps a per-entry model (busy flag, absolute
// ready cycle, payload) plus round-robin pointer and presented-grant memory, compared
// against the DUT every cycle; directed scenarios add literal expectations.
module tb_mem_mshr_ctrl;
   localparam int N  = 4;
   localparam int AW = 27;
   localparam int LW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          alloc_valid_i;
   logic [AW-1:0] alloc_addr_i;
   logic [LW-1:0] alloc_latency_i;
   logic [2:0]    alloc_warp_id_i;
   logic [1:0]    alloc_scb_id_i;
   logic          alloc_ready_o;
   logic          fill_valid_o;
   logic [AW-1:0] fill_addr_o;
   logic [2:0]    fill_warp_id_o;
   logic [1:0]    fill_scb_id_o;
   logic          fill_ready_i;
   logic          neg_fb_valid_o;
   logic [2:0]    neg_fb_warp_id_o;
   logic [1:0]    neg_fb_scb_id_o;
   logic [AW-1:0] probe_addr_i;
   logic          probe_hit_o;
   logic [2:0]    occupancy_o;

   always #5 clk = ~clk;

   mem_mshr_ctrl #(.NUM_ENTRIES(N), .ADDR_W(AW), .LAT_W(LW)) dut (
      .clk              (clk),
      .rst              (rst),
      .alloc_valid_i    (alloc_valid_i),
      .alloc_addr_i     (alloc_addr_i),
      .alloc_latency_i  (alloc_latency_i),
      .alloc_warp_id_i  (alloc_warp_id_i),
      .alloc_scb_id_i   (alloc_scb_id_i),
      .alloc_ready_o    (alloc_ready_o),
      .fill_valid_o     (fill_valid_o),
      .fill_addr_o      (fill_addr_o),
      .fill_warp_id_o   (fill_warp_id_o),
      .fill_scb_id_o    (fill_scb_id_o),
      .fill_ready_i     (fill_ready_i),
      .neg_fb_valid_o   (neg_fb_valid_o),
      .neg_fb_warp_id_o (neg_fb_warp_id_o),
      .neg_fb_scb_id_o  (neg_fb_scb_id_o),
      .probe_addr_i     (probe_addr_i),
      .probe_hit_o      (probe_hit_o),
      .occupancy_o      (occupancy_o)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural model state.
   bit            m_busy [N];
   int            m_rdy  [N];
   logic [AW-1:0] m_addr [N];
   logic [2:0]    m_warp [N];
   logic [1:0]    m_scb  [N];
   int            m_rr;
   bit            m_hold;
   int            m_hold_idx;
   bit            m_neg;
   logic [2:0]    m_negw;
   logic [1:0]    m_negs;
   int            m_cyc = 0;

   bit            e_aready;
   bit            e_fvalid;
   int            e_gnt;
   int            e_occ;
   bit            e_probe;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_busy[i] = 1'b0;
         m_rdy[i]  = 0;
      end
      m_rr   = 0;
      m_hold = 1'b0;
      m_hold_idx = 0;
      m_neg  = 1'b0;
   endtask

   task automatic model_eval();
      e_aready = 1'b0;
      e_occ    = 0;
      e_probe  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!m_busy[i]) e_aready = 1'b1;
         else begin
            e_occ++;
            if (m_addr[i] == probe_addr_i) e_probe = 1'b1;
         end
      end
      e_fvalid = 1'b0;
      e_gnt    = 0;
      if (m_hold) begin
         e_fvalid = 1'b1;
         e_gnt    = m_hold_idx;
      end else begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (!e_fvalid && m_busy[j] && (m_cyc >= m_rdy[j])) begin
               e_fvalid = 1'b1;
               e_gnt    = j;
            end
         end
      end
   endtask

   task automatic model_update();
      bit a_fire;
      bit f_fire;
      int ai;
      int lat;
      a_fire = alloc_valid_i && e_aready;
      f_fire = e_fvalid && fill_ready_i;
      ai = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) ai = i;
      if (f_fire) begin
         m_busy[e_gnt] = 1'b0;
         m_rr   = (e_gnt + 1) % N;
         m_hold = 1'b0;
      end else begin
         m_hold     = e_fvalid;
         m_hold_idx = e_gnt;
      end
      m_neg = a_fire;
      if (a_fire) begin
         lat = (alloc_latency_i == 0) ? 1 : int'(alloc_latency_i);
         m_busy[ai] = 1'b1;
         m_rdy[ai]  = m_cyc + lat;
         m_addr[ai] = alloc_addr_i;
         m_warp[ai] = alloc_warp_id_i;
         m_scb[ai]  = alloc_scb_id_i;
         m_negw = alloc_warp_id_i;
         m_negs = alloc_scb_id_i;
      end
   endtask

   task automatic drive(input logic av, input logic [AW-1:0] a, input logic [LW-1:0] l,
                        input logic [2:0] w, input logic [1:0] s, input logic fr,
                        input logic [AW-1:0] pa);
      alloc_valid_i   = av;
      alloc_addr_i    = a;
      alloc_latency_i = l;
      alloc_warp_id_i = w;
      alloc_scb_id_i  = s;
      fill_ready_i    = fr;
      probe_addr_i    = pa;
   endtask

   // The single per-cycle compare against the model.
   task automatic settle_check();
      #1;
      model_eval();
      chk("alloc_ready", 64'(alloc_ready_o), 64'(e_aready));
      chk("occupancy", 64'(occupancy_o), 64'(e_occ));
      chk("fill_valid", 64'(fill_valid_o), 64'(e_fvalid));
      if (e_fvalid) begin
         chk("fill_addr", 64'(fill_addr_o), 64'(m_addr[e_gnt]));
         chk("fill_warp", 64'(fill_warp_id_o), 64'(m_warp[e_gnt]));
         chk("fill_scb", 64'(fill_scb_id_o), 64'(m_scb[e_gnt]));
      end
      chk("neg_fb_valid", 64'(neg_fb_valid_o), 64'(m_neg));
      if (m_neg) begin
         chk("neg_fb_warp", 64'(neg_fb_warp_id_o), 64'(m_negw));
         chk("neg_fb_scb", 64'(neg_fb_scb_id_o), 64'(m_negs));
      end
      chk("probe_hit", 64'(probe_hit_o), 64'(e_probe));
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      m_cyc++;
      @(negedge clk);
   endtask

   // Called after settle_check; asserts reset mid-cycle, away from any clock edge.
   task automatic do_async_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_alloc_ready", 64'(alloc_ready_o), 64'd1);
      chk("rst_occupancy", 64'(occupancy_o), 64'd0);
      chk("rst_fill_valid", 64'(fill_valid_o), 64'd0);
      chk("rst_neg_fb", 64'(neg_fb_valid_o), 64'd0);
      chk("rst_probe_hit", 64'(probe_hit_o), 64'd0);
      @(posedge clk);
      m_cyc++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1, "watchdog");
   end

   logic [AW-1:0] got_q [$];
   logic [AW-1:0] exp_list [5];

   initial begin
      bit acc;
      rst = 1'b1;
      drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset then idle.
      drive(1'b0, '0, '0, '0, '0, 1'b1, 27'h12);
      settle_check();
      chk("idle_alloc_ready", 64'(alloc_ready_o), 64'd1);
      chk("idle_occupancy", 64'(occupancy_o), 64'd0);
      chk("idle_fill_valid", 64'(fill_valid_o), 64'd0);
      chk("idle_neg_fb", 64'(neg_fb_valid_o), 64'd0);
      advance();

      // Single miss, L=3.
      drive(1'b1, 27'h12, 5'd3, 3'd5, 2'd2, 1'b1, 27'h12);
      settle_check();
      advance();
      drive(1'b0, '0, '0, '0, '0, 1'b1, 27'h12);
      settle_check();
      chk("single_neg_valid", 64'(neg_fb_valid_o), 64'd1);
      chk("single_neg_warp", 64'(neg_fb_warp_id_o), 64'd5);
      chk("single_neg_scb", 64'(neg_fb_scb_id_o), 64'd2);
      chk("single_occ1", 64'(occupancy_o), 64'd1);
      chk("single_probe", 64'(probe_hit_o), 64'd1);
      chk("single_fill_early1", 64'(fill_valid_o), 64'd0);
      advance();
      settle_check();
      chk("single_fill_early2", 64'(fill_valid_o), 64'd0);
      chk("single_neg_once", 64'(neg_fb_valid_o), 64'd0);
      advance();
      settle_check();
      chk("single_fill_valid", 64'(fill_valid_o), 64'd1);
      chk("single_fill_addr", 64'(fill_addr_o), 64'h12);
      advance();
      settle_check();
      chk("single_occ0", 64'(occupancy_o), 64'd0);
      do_async_reset();

      // Fill up, backpressure, round-robin order and re-alloc of entry 0.
      for (int i = 0; i < 4; i++) begin
         exp_list[i] = 27'h100 + AW'(i);
         drive(1'b1, exp_list[i], 5'd2, 3'(i), 2'(i), 1'b0, exp_list[0]);
         settle_check();
         advance();
      end
      exp_list[4] = 27'h104;
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, exp_list[4], 5'd1, 3'd4, 2'd0, 1'b0, exp_list[4]);
         settle_check();
         chk("full_alloc_ready", 64'(alloc_ready_o), 64'd0);
         chk("full_occupancy", 64'(occupancy_o), 64'd4);
         chk("bp_fill_valid", 64'(fill_valid_o), 64'd1);
         chk("bp_fill_addr", 64'(fill_addr_o), 64'(exp_list[0]));
         advance();
      end
      acc = 1'b0;
      for (int c = 0; c < 20 && got_q.size() < 5; c++) begin
         drive(!acc, exp_list[4], 5'd1, 3'd4, 2'd0, 1'b1, exp_list[4]);
         settle_check();
         if (got_q.size() == 0) chk("held_alloc_blocked", 64'(alloc_ready_o), 64'd0);
         if (got_q.size() == 1) chk("held_alloc_accept", 64'(alloc_ready_o), 64'd1);
         if (fill_valid_o) got_q.push_back(fill_addr_o);
         if (alloc_valid_i && alloc_ready_o) acc = 1'b1;
         advance();
      end
      chk("rr_fill_count", 64'(got_q.size()), 64'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < got_q.size()) chk("rr_order", 64'(got_q[i]), 64'(exp_list[i]));
      end

      // Async reset with one entry stalled on the fill port and one mid-countdown.
      drive(1'b1, 27'h200, 5'd1, 3'd1, 2'd1, 1'b0, 27'h200);
      settle_check();
      advance();
      drive(1'b1, 27'h201, 5'd20, 3'd2, 2'd3, 1'b0, 27'h201);
      settle_check();
      advance();
      drive(1'b0, '0, '0, '0, '0, 1'b0, 27'h201);
      settle_check();
      chk("stall_fill_valid", 64'(fill_valid_o), 64'd1);
      chk("stall_fill_addr", 64'(fill_addr_o), 64'h200);
      do_async_reset();
      for (int c = 0; c < 25; c++) begin
         drive(1'b0, '0, '0, '0, '0, 1'b1, 27'h201);
         settle_check();
         chk("post_rst_fill", 64'(fill_valid_o), 64'd0);
         chk("post_rst_neg", 64'(neg_fb_valid_o), 64'd0);
         advance();
      end

      // Randomized traffic with a small address pool (duplicates) and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         logic [LW-1:0] lat;
         lat = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 31))
                                           : LW'($urandom_range(0, 6));
         drive(($urandom_range(0, 2) != 0), AW'(32'h40 + $urandom_range(0, 5)), lat,
               3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) != 0), AW'(32'h40 + $urandom_range(0, 6)));
         settle_check();
         if ($urandom_range(0, 299) == 0) do_async_reset();
         else advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
